count_monitor: RTL and testbench

Sequence checker that sits directly downstream of the 4-bit down counter and consumes its `count` output every sampled cycle. It verifies that the stream decrements by exactly one modulo 16. It flags wrap-around (0→15) and reload (15 after a non-zero value) events, counts wraps, and raises an error on any illegal step. Typical use is as a self-check / event source for the counter stage in both silicon and benches.

---
 rtl/count_monitor.sv | 102 ++++++++++
 tb/tb_count_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Sequence checker for the 4-bit down counter: flags wraps, reloads and illegal steps.
// Define COUNT_MON_STICKY_ERR_EN for a sticky ERROR state instead of a one-cycle err pulse.
module count_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count_in,
  input  logic              valid,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic              reload_pulse,
  output logic              err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [3:0]        last,
  output logic              tracking
);

`ifdef COUNT_MON_STICKY_ERR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1
  } state_t;
`endif

  localparam logic [WRAP_W-1:0] WMAX = '1;

  state_t     state;
  logic [3:0] exp_v;
  logic       is_wrap;
  logic       is_reload;
  logic       step_ok;

  // last doubles as the previous sample used for the step check
  assign exp_v     = last - 4'd1;
  assign is_wrap   = (last == 4'd0) && (count_in == 4'hf);
  assign is_reload = (last != 4'd0) && (count_in == 4'hf);
  assign step_ok   = (last != 4'd0) && (count_in == exp_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 4'd0;
      wrap_cnt     <= '0;
      wrap_pulse   <= 1'b0;
      reload_pulse <= 1'b0;
      err          <= 1'b0;
      tracking     <= 1'b0;
    end else begin
      wrap_pulse   <= 1'b0;
      reload_pulse <= 1'b0;
`ifndef COUNT_MON_STICKY_ERR_EN
      err          <= 1'b0;
`endif
      if (clr) begin
        state    <= IDLE;
        wrap_cnt <= '0;
        err      <= 1'b0;
        tracking <= 1'b0;
      end else if (valid) begin
        last <= count_in;
        unique case (state)
          IDLE: begin
            state    <= TRACK;
            tracking <= 1'b1;
          end
          TRACK: begin
            if (is_wrap) begin
              wrap_pulse <= 1'b1;
              if (wrap_cnt != WMAX)
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end else if (is_reload) begin
              reload_pulse <= 1'b1;
            end else if (!step_ok) begin
              err <= 1'b1;
`ifdef COUNT_MON_STICKY_ERR_EN
              state    <= ERROR;
              tracking <= 1'b0;
`endif
            end
          end
`ifdef COUNT_MON_STICKY_ERR_EN
          ERROR: begin
            state <= ERROR;
          end
`endif
          default: begin
            state    <= IDLE;
            tracking <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed table, plan sequences and random stream
// against a behavioural model; a WRAP_W=2 instance covers saturation.
module tb_count_monitor;

`ifdef COUNT_MON_STICKY_ERR_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic       valid = 1'b0;
  logic       clr = 1'b0;

  logic       wp_a, rp_a, err_a, trk_a;
  logic [7:0] wc_a;
  logic [3:0] last_a;
  logic       wp_b, rp_b, err_b, trk_b;
  logic [1:0] wc_b;
  logic [3:0] last_b;

  always #5 clk = ~clk;

  count_monitor dut (
    .clk(clk), .rst(rst), .count_in(count_in), .valid(valid), .clr(clr),
    .wrap_pulse(wp_a), .reload_pulse(rp_a), .err(err_a),
    .wrap_cnt(wc_a), .last(last_a), .tracking(trk_a)
  );

  count_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in), .valid(valid), .clr(clr),
    .wrap_pulse(wp_b), .reload_pulse(rp_b), .err(err_b),
    .wrap_cnt(wc_b), .last(last_b), .tracking(trk_b)
  );

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit       m_trk, m_stk, m_wp, m_rp, m_err;
  bit [3:0] m_last;
  int       m_w8, m_w2;
  int       nwp;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_trk = 0; m_stk = 0; m_wp = 0; m_rp = 0; m_err = 0;
    m_last = 0; m_w8 = 0; m_w2 = 0;
  endfunction

  function automatic void model(bit v, bit [3:0] c, bit cl);
    int p;
    int ci;
    m_wp = 0;
    m_rp = 0;
    if (!m_stk) m_err = 0;
    if (cl) begin
      m_trk = 0; m_stk = 0; m_err = 0; m_w8 = 0; m_w2 = 0;
      return;
    end
    if (!v) return;
    p  = int'(m_last);
    ci = int'(c);
    if (m_stk) begin
      m_last = c;
    end else if (!m_trk) begin
      m_trk  = 1;
      m_last = c;
    end else begin
      if (p != 0 && ci == (p + 15) % 16) begin
      end else if (p == 0 && ci == 15) begin
        m_wp = 1;
        m_w8 = (m_w8 < 255) ? m_w8 + 1 : 255;
        m_w2 = (m_w2 < 3) ? m_w2 + 1 : 3;
      end else if (ci == 15) begin
        m_rp = 1;
      end else begin
        m_err = 1;
        if (STK) begin
          m_stk = 1;
          m_trk = 0;
        end
      end
      m_last = c;
    end
  endfunction

  task automatic check_all();
    chk("wrap_pulse", 32'(wp_a), 32'(m_wp));
    chk("reload_pulse", 32'(rp_a), 32'(m_rp));
    chk("err", 32'(err_a), 32'(m_err));
    chk("tracking", 32'(trk_a), 32'(m_trk));
    chk("last", 32'(last_a), 32'(m_last));
    chk("wrap_cnt", 32'(wc_a), 32'(m_w8));
    chk("w2_wrap_pulse", 32'(wp_b), 32'(m_wp));
    chk("w2_err", 32'(err_b), 32'(m_err));
    chk("w2_wrap_cnt", 32'(wc_b), 32'(m_w2));
  endtask

  // call at a negedge; returns at the following negedge after checking
  task automatic step(input bit v, input bit [3:0] c, input bit cl);
    valid = v;
    count_in = c;
    clr = cl;
    @(posedge clk);
    model(v, c, cl);
    @(negedge clk);
    check_all();
    if (m_wp) nwp++;
  endtask

  typedef struct {
    bit       v;
    bit       cl;
    bit [3:0] c;
    bit       wp;
    bit       rp;
    bit       er;
    bit       trk;
    bit [3:0] lst;
  } vec_t;

  vec_t tv[13];

  initial begin
    bit [3:0] c;
    int r;

    tv[0]  = '{1, 0, 4'd9,  0, 0, 0,   1,    4'd9};
    tv[1]  = '{1, 0, 4'd8,  0, 0, 0,   1,    4'd8};
    tv[2]  = '{1, 0, 4'd15, 0, 1, 0,   1,    4'd15};
    tv[3]  = '{1, 0, 4'd14, 0, 0, 0,   1,    4'd14};
    tv[4]  = '{0, 0, 4'd0,  0, 0, 0,   1,    4'd14};
    tv[5]  = '{1, 1, 4'd3,  0, 0, 0,   0,    4'd14};
    tv[6]  = '{1, 0, 4'd6,  0, 0, 0,   1,    4'd6};
    tv[7]  = '{1, 0, 4'd5,  0, 0, 0,   1,    4'd5};
    tv[8]  = '{1, 0, 4'd5,  0, 0, 1,   !STK, 4'd5};
    tv[9]  = '{1, 0, 4'd4,  0, 0, STK, !STK, 4'd4};
    tv[10] = '{1, 0, 4'd3,  0, 0, STK, !STK, 4'd3};
    tv[11] = '{1, 1, 4'd3,  0, 0, 0,   0,    4'd3};
    tv[12] = '{1, 0, 4'd2,  0, 0, 0,   1,    4'd2};

    model_reset();
    nwp = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // directed table: reload, clr priority, stall
    foreach (tv[i]) begin
      step(tv[i].v, tv[i].c, tv[i].cl);
      chk($sformatf("tv%0d_wp", i), 32'(wp_a), 32'(tv[i].wp));
      chk($sformatf("tv%0d_rp", i), 32'(rp_a), 32'(tv[i].rp));
      chk($sformatf("tv%0d_err", i), 32'(err_a), 32'(tv[i].er));
      chk($sformatf("tv%0d_trk", i), 32'(trk_a), 32'(tv[i].trk));
      chk($sformatf("tv%0d_last", i), 32'(last_a), 32'(tv[i].lst));
    end
    chk("tv_wrap_cnt", 32'(wc_a), 32'd0);

    // full count-down with one wrap, then four more wraps
    step(1, 4'd0, 1);
    nwp = 0;
    for (int k = 15; k >= 0; k--) step(1, 4'(k), 0);
    step(1, 4'd15, 0);
    chk("wrap1_pulse", 32'(wp_a), 32'd1);
    step(1, 4'd14, 0);
    chk("wrap1_pulse_end", 32'(wp_a), 32'd0);
    chk("wrap1_cnt", 32'(wc_a), 32'd1);
    for (int w = 0; w < 4; w++) begin
      for (int k = 13; k >= 0; k--) step(1, 4'(k), 0);
      step(1, 4'd15, 0);
      step(1, 4'd14, 0);
    end
    chk("wrap5_pulses", 32'(nwp), 32'd5);
    chk("wrap5_cnt8", 32'(wc_a), 32'd5);
    chk("wrap5_cnt2_sat", 32'(wc_b), 32'd3);
    chk("wrap5_err", 32'(err_a), 32'd0);

    // asynchronous reset between edges
    step(1, 4'd13, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'd7, 0);
    chk("post_rst_err", 32'(err_a), 32'd0);
    chk("post_rst_trk", 32'(trk_a), 32'd1);
    chk("post_rst_last", 32'(last_a), 32'd7);

    // random stream against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) c = m_last - 4'd1;
      else if (r < 80) c = 4'd15;
      else if (r < 85) c = m_last;
      else c = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 8, c, $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
